// File: rtl/regwr_pkg.sv
// Shared definitions for the register-write arbiter: address map, FSM states
// and the SETUP counter width.
package regwr_pkg;

    localparam int SETUP_W = 3;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_CFG0   = 3'd1;
    localparam logic [2:0] ADDR_CFG1   = 3'd2;
    localparam logic [2:0] ADDR_CFG2   = 3'd3;
    localparam logic [2:0] ADDR_WDDIV  = 3'd4;
    localparam logic [2:0] ADDR_WDKICK = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_ACK
    } state_t;

    function automatic logic addr_valid(input logic [2:0] addr);
        return addr <= ADDR_WDKICK;
    endfunction

    // Config registers are frozen while the motor runs; control and kick are not.
    function automatic logic addr_lockable(input logic [2:0] addr);
        return (addr >= ADDR_CFG0) && (addr <= ADDR_WDDIV);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter with a last-grant pointer; grants are only issued while
// the caller is able to take a new transaction.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic take,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (take) begin
            if (req_a && req_b) begin
                if ((FIXED_PRIO != 0) || last_b) gnt_a = 1'b1;
                else                             gnt_b = 1'b1;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      last_b <= 1'b1;
        else if (gnt_a) last_b <= 1'b0;
        else if (gnt_b) last_b <= 1'b1;
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Arbitrates host and sequencer register writes onto one shared data bus with
// per-register load strobes, a setup window and a motor-running lockout.
//
// state     | meaning
// ST_IDLE   | waiting for a request; wrtdata holds the last written value
// ST_SETUP  | wrtdata driven, strobes low, SETUP cycles counted down
// ST_STROBE | one-cycle load strobe (or watchdog kick) for the latched address
// ST_ACK    | one-cycle ack to the winner, err set if the write was rejected
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int SETUP      = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ack,
    output logic       a_err,
    input  logic       b_req,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic       b_err,
    input  logic       motorenaint,
    output logic [7:0] wrtdata,
    output logic       ctrlld,
    output logic       cfgld0,
    output logic       cfgld1,
    output logic       cfgld2,
    output logic       wdogdivld,
    output logic       wdreset,
    output logic       busy
);

    state_t             state, state_nxt;
    logic [SETUP_W-1:0] cnt;
    logic [2:0]         addr_q;
    logic               owner_b;
    logic               reject_q;
    logic               reject_now;
    logic               gnt_a, gnt_b;
    logic               strobe;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk   (clk),
        .reset (reset),
        .take  (state == ST_IDLE),
        .req_a (a_req),
        .req_b (b_req),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // Evaluated against motorenaint in the final SETUP cycle only.
    assign reject_now = !addr_valid(addr_q) || (addr_lockable(addr_q) && motorenaint);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (a_req || b_req) state_nxt = ST_SETUP;
            ST_SETUP:  if (cnt == '0) state_nxt = reject_now ? ST_ACK : ST_STROBE;
            ST_STROBE: state_nxt = ST_ACK;
            ST_ACK:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            wrtdata  <= '0;
            owner_b  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            if (gnt_a || gnt_b) begin
                addr_q  <= gnt_b ? b_addr : a_addr;
                wrtdata <= gnt_b ? b_data : a_data;
                owner_b <= gnt_b;
                cnt     <= SETUP_W'(SETUP - 1);
            end
            if (state == ST_SETUP) begin
                if (cnt != '0) cnt      <= cnt - 1'b1;
                else           reject_q <= reject_now;
            end
        end
    end

    assign strobe    = (state == ST_STROBE);
    assign ctrlld    = strobe && (addr_q == ADDR_CTRL);
    assign cfgld0    = strobe && (addr_q == ADDR_CFG0);
    assign cfgld1    = strobe && (addr_q == ADDR_CFG1);
    assign cfgld2    = strobe && (addr_q == ADDR_CFG2);
    assign wdogdivld = strobe && (addr_q == ADDR_WDDIV);
    assign wdreset   = strobe && (addr_q == ADDR_WDKICK);

    assign a_ack = (state == ST_ACK) && !owner_b;
    assign b_ack = (state == ST_ACK) && owner_b;
    assign a_err = a_ack && reject_q;
    assign b_err = b_ack && reject_q;
    assign busy  = (state != ST_IDLE);

endmodule
